// File: rtl/mem_bank_arbiter_if.sv
// Request/response bundle between requesters and the memory bank arbiter.
//   master : requester side; drives read/write requests and receives grants and read data
//   slave  : arbiter side; receives requests and drives grants and read data
// All per-requester fields are packed arrays indexed by requester number.
interface mem_bank_arbiter_if #(
    parameter int unsigned REQUESTERS = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] r_addr;
    logic [REQUESTERS-1:0]                 r_avalid;
    logic [REQUESTERS-1:0]                 r_aready;
    logic [REQUESTERS-1:0]                 r_dvalid;
    logic [REQUESTERS-1:0][DATA_WIDTH-1:0] r_data;
    logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] w_addr;
    logic [REQUESTERS-1:0][DATA_WIDTH-1:0] w_data;
    logic [REQUESTERS-1:0]                 w_valid;
    logic [REQUESTERS-1:0]                 w_ready;

    modport master (
        output r_addr, r_avalid, w_addr, w_data, w_valid,
        input  r_aready, r_dvalid, r_data, w_ready
    );

    modport slave (
        input  r_addr, r_avalid, w_addr, w_data, w_valid,
        output r_aready, r_dvalid, r_data, w_ready
    );
endinterface

// File: rtl/mem_bank_arbiter.sv
// Single-port memory bank shared by REQUESTERS read/write ports.
// One access per cycle: independent round-robin pointers pick a read and a write candidate,
// and a last-type flag alternates between read and write when both are pending.
// Read data returns DATA_LAT cycles after accept through an in-order response pipeline.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : request/response bundle (slave side), see mem_bank_arbiter_if
module mem_bank_arbiter #(
    parameter int unsigned REQUESTERS = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_LAT   = 2
) (
    input logic               clk,
    input logic               rst,
    mem_bank_arbiter_if.slave bus
);
    localparam int unsigned IdxW  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth];

    logic [IdxW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [IdxW-1:0] rd_idx, wr_idx;
    logic            rd_any, wr_any;
    logic            grant_r, grant_w;
    logic            last_read_q, last_read_d;

    // Response pipeline: one entry per latency stage.
    logic [DATA_LAT-1:0]                 pv_q;
    logic [DATA_LAT-1:0][IdxW-1:0]       pidx_q;
    logic [DATA_LAT-1:0][DATA_WIDTH-1:0] pdata_q;
    logic [REQUESTERS-1:0][DATA_WIDTH-1:0] r_data_q;
    logic [REQUESTERS-1:0]                 dvalid;

    function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] p);
        return (p == IdxW'(REQUESTERS - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin candidate search starting at each pointer.
    always_comb begin
        logic [IdxW-1:0] rc;
        logic [IdxW-1:0] wc;
        rc     = '0;
        wc     = '0;
        rd_any = 1'b0;
        wr_any = 1'b0;
        rd_idx = '0;
        wr_idx = '0;
        for (int k = 0; k < int'(REQUESTERS); k++) begin
            rc = IdxW'((int'(rd_ptr_q) + k) % int'(REQUESTERS));
            wc = IdxW'((int'(wr_ptr_q) + k) % int'(REQUESTERS));
            if (!rd_any && bus.r_avalid[rc]) begin
                rd_any = 1'b1;
                rd_idx = rc;
            end
            if (!wr_any && bus.w_valid[wc]) begin
                wr_any = 1'b1;
                wr_idx = wc;
            end
        end
    end

    // Read/write choice; ready is a pure function of valid, pointers and flag.
    always_comb begin
        grant_w      = ~rst & wr_any & (~rd_any | last_read_q);
        grant_r      = ~rst & rd_any & ~grant_w;
        bus.r_aready = '0;
        bus.w_ready  = '0;
        if (grant_r) bus.r_aready[rd_idx] = 1'b1;
        if (grant_w) bus.w_ready[wr_idx] = 1'b1;
        rd_ptr_d    = grant_r ? next_ptr(rd_idx) : rd_ptr_q;
        wr_ptr_d    = grant_w ? next_ptr(wr_idx) : wr_ptr_q;
        last_read_d = grant_r ? 1'b1 : (grant_w ? 1'b0 : last_read_q);
    end

    // Response outputs; r_data holds the last delivered word per requester.
    always_comb begin
        dvalid = '0;
        if (pv_q[DATA_LAT-1]) dvalid[pidx_q[DATA_LAT-1]] = 1'b1;
        bus.r_dvalid = dvalid;
        for (int i = 0; i < int'(REQUESTERS); i++) begin
            bus.r_data[i] = dvalid[i] ? pdata_q[DATA_LAT-1] : r_data_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            last_read_q <= 1'b1;
            pv_q        <= '0;
            r_data_q    <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            last_read_q <= last_read_d;
            // No write can share the cycle, so the current array is the end-of-cycle value.
            pv_q[0]     <= grant_r;
            pidx_q[0]   <= rd_idx;
            pdata_q[0]  <= mem[bus.r_addr[rd_idx]];
            for (int k = 1; k < int'(DATA_LAT); k++) begin
                pv_q[k]    <= pv_q[k-1];
                pidx_q[k]  <= pidx_q[k-1];
                pdata_q[k] <= pdata_q[k-1];
            end
            for (int i = 0; i < int'(REQUESTERS); i++) begin
                if (dvalid[i]) r_data_q[i] <= pdata_q[DATA_LAT-1];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (grant_w) mem[bus.w_addr[wr_idx]] <= bus.w_data[wr_idx];
    end
endmodule

// File: tb/tb_mem_bank_arbiter.sv
module tb_mem_bank_arbiter;
    localparam int unsigned N   = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 4;
    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bank_arbiter_if #(.REQUESTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_bank_arbiter #(
        .REQUESTERS(N),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DATA_LAT  (LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          sb[$];
    logic [DW-1:0] model_mem [2**AW];
    logic [DW-1:0] exp_rdata [N];
    int            cyc;
    int            n_vec;
    int            n_miss;
    bit            armed;
    logic [N-1:0]  g_r;
    logic [N-1:0]  g_w;
    int            last_rsp_port;
    logic [DW-1:0] last_rsp_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Per-cycle observer: invariants, scoreboard push on accept, pop on response.
    task automatic monitor();
        int   nd;
        int   dp;
        rsp_t e;
        g_r = bus.r_aready;
        g_w = bus.w_ready;
        check("ready_onehot0", 64'($countones({g_r, g_w}) <= 1), 64'd1);
        check("r_ready_without_valid", 64'(g_r & ~bus.r_avalid), 64'd0);
        check("w_ready_without_valid", 64'(g_w & ~bus.w_valid), 64'd0);
        if (rst) check("ready_in_reset", 64'({g_r, g_w}), 64'd0);
        if (armed) begin
            nd = $countones(bus.r_dvalid);
            if (nd != 0) begin
                check("dvalid_onehot", 64'(nd), 64'd1);
                dp = 0;
                for (int i = N - 1; i >= 0; i--) if (bus.r_dvalid[i]) dp = i;
                if (sb.size() == 0) begin
                    check("dvalid_spurious", 64'(bus.r_dvalid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_port", 64'(dp), 64'(e.port));
                    check("rsp_data", 64'(bus.r_data[dp]), 64'(e.data));
                    check("rsp_cycle", 64'(cyc), 64'(e.due));
                    exp_rdata[e.port] = e.data;
                end
                last_rsp_port = dp;
                last_rsp_data = bus.r_data[dp];
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("rsp_missing_dvalid", 64'(bus.r_dvalid), 64'(1) << e.port);
            end
            for (int i = 0; i < N; i++) begin
                if (!bus.r_dvalid[i]) check("r_data_hold", 64'(bus.r_data[i]), 64'(exp_rdata[i]));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (g_r[i]) sb.push_back('{port: i, data: model_mem[bus.r_addr[i]], due: cyc + LAT});
        end
        for (int i = 0; i < N; i++) begin
            if (g_w[i]) model_mem[bus.w_addr[i]] = bus.w_data[i];
        end
        if (rst) begin
            sb.delete();
            for (int i = 0; i < N; i++) exp_rdata[i] = '0;
            armed = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        bus.r_avalid = '0;
        bus.w_valid  = '0;
    endtask

    task automatic do_reset(input int cycles);
        idle();
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        cyc = 0;
        armed = 1'b0;
        rst = 1'b1;
        bus.r_addr = '0;
        bus.w_addr = '0;
        bus.w_data = '0;
        idle();
        @(posedge clk);
        #1;

        // Reset state
        do_reset(2);
        check("reset_dvalid", 64'(bus.r_dvalid), 64'd0);
        check("reset_rdata", 64'(bus.r_data[0] | bus.r_data[1] | bus.r_data[2]), 64'd0);

        // Preload addresses 0..5, single writer per cycle
        for (int a = 0; a < 6; a++) begin
            idle();
            bus.w_valid[a % N] = 1'b1;
            bus.w_addr[a % N]  = AW'(a);
            bus.w_data[a % N]  = 32'h1000_0000 + 32'(a);
            step();
            check("preload_grant", 64'(g_w), 64'(1) << (a % N));
        end
        idle();

        // Write port 0 then read port 1 of the same address
        bus.w_valid[0] = 1'b1;
        bus.w_addr[0]  = 4'd3;
        bus.w_data[0]  = 32'hA5A5_0001;
        step();
        check("wr_then_rd_wgrant", 64'(g_w), 64'b001);
        idle();
        bus.r_avalid[1] = 1'b1;
        bus.r_addr[1]   = 4'd3;
        step();
        check("wr_then_rd_rgrant", 64'(g_r), 64'b010);
        idle();
        check("wr_then_rd_lat1_dvalid", 64'(bus.r_dvalid), 64'd0);
        step();
        check("wr_then_rd_lat2_dvalid", 64'(bus.r_dvalid), 64'b010);
        check("wr_then_rd_data", 64'(bus.r_data[1]), 64'hA5A5_0001);
        step();
        step();

        // All three readers held: rotation 0,1,2,0,1,2
        do_reset(1);
        for (int k = 0; k < 6; k++) begin
            bus.r_avalid = '1;
            for (int j = 0; j < N; j++) bus.r_addr[j] = AW'((k + j) % 6);
            step();
            check("rr_read_grant", 64'(g_r), 64'(1) << (k % N));
        end
        idle();
        for (int k = 0; k <= LAT; k++) step();

        // Read and write contending: W,R,W,R
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            bus.w_valid  = 3'b100;
            bus.w_addr[2] = 4'd7;
            bus.w_data[2] = 32'h7700_0000 + 32'(k);
            bus.r_avalid = 3'b001;
            bus.r_addr[0] = 4'd7;
            step();
            check("alt_wgrant", 64'(g_w), (k % 2 == 0) ? 64'b100 : 64'd0);
            check("alt_rgrant", 64'(g_r), (k % 2 == 0) ? 64'd0 : 64'b001);
        end
        idle();
        for (int k = 0; k <= LAT; k++) step();
        check("alt_last_read_data", 64'(last_rsp_data), 64'h7700_0002);

        // Same-address write and read pending together
        bus.w_valid[1] = 1'b1;
        bus.w_addr[1]  = 4'd9;
        bus.w_data[1]  = 32'hDEAD_0039;
        bus.r_avalid[2] = 1'b1;
        bus.r_addr[2]   = 4'd9;
        step();
        check("same_addr_wfirst", 64'({g_r, g_w}), 64'b000_010);
        bus.w_valid = '0;
        step();
        check("same_addr_rnext", 64'({g_r, g_w}), 64'b100_000);
        idle();
        for (int k = 0; k < LAT; k++) step();
        check("same_addr_rsp_port", 64'(last_rsp_port), 64'd2);
        check("same_addr_rsp_data", 64'(last_rsp_data), 64'hDEAD_0039);

        // Reset with reads in flight
        bus.r_avalid = 3'b011;
        bus.r_addr[0] = 4'd4;
        bus.r_addr[1] = 4'd5;
        step();
        check("flush_grant0", 64'(g_r), 64'b001);
        step();
        check("flush_grant1", 64'(g_r), 64'b010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            check("flush_no_dvalid", 64'(bus.r_dvalid), 64'd0);
            check("flush_rdata_zero", 64'(bus.r_data[0] | bus.r_data[1] | bus.r_data[2]), 64'd0);
            step();
        end
        bus.r_avalid = '1;
        for (int j = 0; j < N; j++) bus.r_addr[j] = AW'(j);
        step();
        check("flush_next_grant", 64'(g_r), 64'b001);
        idle();
        for (int k = 0; k <= LAT; k++) step();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mem_bank_arbiter.md
MEM_BANK_ARBITER -- requirements
Module: mem_bank_arbiter

Interface
REQ-001 Parameter REQUESTERS, default 3: number of requester ports; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 32: data word width.
REQ-003 Parameter ADDR_WIDTH, default 4: address width; storage depth is 2^ADDR_WIDTH words.
REQ-004 Parameter DATA_LAT, default 2: read latency in cycles; legal range 1..4.
REQ-005 Port clk, input, 1: single clock; all logic on rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port r_addr, input, [REQUESTERS][ADDR_WIDTH]: read address per requester.
REQ-008 Port r_avalid, input, [REQUESTERS]: 1 = read request pending.
REQ-009 Port r_aready, output, [REQUESTERS]: 1 = read request accepted this cycle.
REQ-010 Port r_dvalid, output, [REQUESTERS]: 1 = r_data valid for that requester.
REQ-011 Port r_data, output, [REQUESTERS][DATA_WIDTH]: read response data.
REQ-012 Port w_addr, input, [REQUESTERS][ADDR_WIDTH]: write address per requester.
REQ-013 Port w_data, input, [REQUESTERS][DATA_WIDTH]: write data per requester.
REQ-014 Port w_valid, input, [REQUESTERS]: 1 = write request pending.
REQ-015 Port w_ready, output, [REQUESTERS]: 1 = write accepted this cycle.

Function
REQ-016 Single-port storage SHALL perform at most one access per cycle, read or write.
REQ-017 A transfer SHALL occur when valid and ready are both 1 in the same cycle; ready is a combinational grant and may depend on valid.
REQ-018 At most one bit across r_aready and w_ready SHALL be 1 in any cycle; ready SHALL never be 1 on a port whose valid is 0.
REQ-019 Read arbitration: round-robin over r_avalid; after granting port i, port (i+1) mod REQUESTERS SHALL have highest read priority.
REQ-020 Write arbitration: an independent round-robin pointer over w_valid, with the same rotation rule.
REQ-021 Read/write choice when only one type is pending: grant that type.
REQ-022 Read/write choice when both types are pending: grant the type not granted in the most recent granted cycle; after reset, write wins first.
REQ-023 Arbitration pointers and the last-type flag SHALL update only in cycles with a grant.
REQ-024 Write accepted in cycle T: mem[w_addr] SHALL be updated at the end of cycle T.
REQ-025 A read of the same address accepted in T+1 or later SHALL return the new data.
REQ-026 Read accepted from port i in cycle T: r_dvalid[i] SHALL be 1 for exactly one cycle, at T+DATA_LAT.
REQ-027 In that cycle, r_data[i] SHALL hold mem[addr] as it stood at the end of cycle T.
REQ-028 Response pipeline: DATA_LAT stages, each carrying valid, requester index and data; one read may be issued every cycle with no bubbles.
REQ-029 r_data[i] SHALL hold its last value while r_dvalid[i] = 0; it is 0 after reset.
REQ-030 Responses SHALL return in issue order; no backpressure on responses.
REQ-031 Requests held across cycles without ready are not dropped; address and data are sampled only in the accept cycle.

Reset
REQ-032 On rst = 1 at a clock edge, the following SHALL be cleared: r_dvalid = 0, r_data = 0, both pointers = 0, last-type flag = read (so write wins first).
REQ-033 On reset, all in-flight read responses SHALL be discarded, with no r_dvalid afterwards.
REQ-034 While rst = 1, all r_aready and w_ready SHALL be 0.
REQ-035 Storage contents are not reset.

Verification
REQ-036 Write port 0 addr 3 data 0xA5A5_0001; read port 1 addr 3 the next cycle -> r_dvalid[1] = 1 exactly 2 cycles after accept, r_data[1] = 0xA5A5_0001.
REQ-037 All 3 r_avalid held high for 6 cycles after reset -> r_aready grants rotate 0,1,2,0,1,2; r_dvalid follows the same order with 2-cycle lag and one response per cycle.
REQ-038 w_valid[2] and r_avalid[0] both held high -> grants alternate W,R,W,R starting with W.
REQ-039 Write then read of the same address in the same cycle as the write (both pending) -> write granted first, read granted next cycle, and the read returns the new data.
REQ-040 Assert rst for 1 cycle while 2 reads are in flight -> no r_dvalid in the following 3 cycles, r_data = 0, next grant goes to port 0.
REQ-041 Each bench cycle checks: one-hot-or-zero across {r_aready, w_ready}; no ready without valid; one r_dvalid per accepted read.
